// File: rtl/parallel_sorter_pkg.sv
// Shared definitions for the parallel sorter self-test block.
//   VEC_W        : packed vector width at the default sizing (3-bit words x 2)
//   MAX_W        : widest vector the unpack helper handles
//   elem(v,i,dw) : returns word i of a packed vector of dw-bit words,
//                  zero-extended to MAX_W bits
package parallel_sorter_pkg;

  localparam int DEF_DATA_WIDTH = 3;
  localparam int DEF_NUM_ELEM   = 2;
  localparam int VEC_W          = DEF_DATA_WIDTH * DEF_NUM_ELEM;
  localparam int MAX_W          = 64;

  function automatic logic [MAX_W-1:0] elem(input logic [MAX_W-1:0] vec,
                                            input int               i,
                                            input int               dw);
    logic [MAX_W-1:0] mask;
    mask = (dw >= MAX_W) ? '1 : ((MAX_W'(1) << dw) - MAX_W'(1));
    return (vec >> (i * dw)) & mask;
  endfunction

endpackage

// File: rtl/parallel_sorter.sv
// Combinational rank-based sorter.
//   inps : num_elem packed unsigned words, word i at [i*dw +: dw]
//   outp : the same words in ascending order, smallest in slot 0
// Each word's rank is the number of words that must precede it: strictly
// smaller words, plus equal words at a lower index. The tie rule makes the
// ranks a permutation, so every output slot selects exactly one input word.
module parallel_sorter
  import parallel_sorter_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int num_elem   = DEF_NUM_ELEM
) (
  input  logic [num_elem*data_width-1:0] inps,
  output logic [num_elem*data_width-1:0] outp
);

  localparam int W  = num_elem * data_width;
  localparam int RW = (num_elem > 1) ? $clog2(num_elem) : 1;

  logic [num_elem-1:0][data_width-1:0] w_x;
  logic [num_elem-1:0][data_width-1:0] w_sorted;
  logic [num_elem-1:0][num_elem-1:0]   w_before;  // [i][j]: word j sorts ahead of word i
  logic [num_elem-1:0][RW-1:0]         w_rank;

  logic [MAX_W-1:0] w_inps_ext;
  assign w_inps_ext = MAX_W'(inps);

  for (genvar i = 0; i < num_elem; i++) begin : g_unpack
    assign w_x[i] = data_width'(elem(w_inps_ext, i, data_width));
  end

  // Comparator array
  for (genvar i = 0; i < num_elem; i++) begin : g_row
    for (genvar j = 0; j < num_elem; j++) begin : g_col
      if (j < i) begin : g_lo
        assign w_before[i][j] = (w_x[j] <= w_x[i]);
      end else begin : g_hi
        assign w_before[i][j] = (w_x[j] <  w_x[i]);
      end
    end
  end

  // Rank adders
  always_comb begin
    w_rank = '0;
    for (int i = 0; i < num_elem; i++) begin
      for (int j = 0; j < num_elem; j++) begin
        w_rank[i] = w_rank[i] + RW'(w_before[i][j]);
      end
    end
  end

  // Output mux per slot
  always_comb begin
    w_sorted = '0;
    for (int k = 0; k < num_elem; k++) begin
      for (int i = 0; i < num_elem; i++) begin
        if (w_rank[i] == RW'(k)) w_sorted[k] = w_sorted[k] | w_x[i];
      end
    end
  end

  assign outp = W'(w_sorted);

endmodule

// File: rtl/parallel_sorter_selftest.sv
// Self-stimulating sorter wrapper: a free-running counter feeds the sorter
// so that only a clock and reset are needed to sweep every input pattern.
//   clk       : clock, all state on posedge
//   rst       : synchronous active-high reset, clears the counter
//   outp      : sorted vector (ascending, smallest at the LSB slot)
//   outp_inps : current unsorted vector, straight from the counter register
module parallel_sorter_selftest
  import parallel_sorter_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int num_elem   = DEF_NUM_ELEM
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [num_elem*data_width-1:0] outp,
  output logic [num_elem*data_width-1:0] outp_inps
);

  localparam int W = num_elem * data_width;

  logic [W-1:0] r_count;
  logic [W-1:0] w_sorted;

  // Wraps naturally from all-ones to zero
  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else     r_count <= r_count + W'(1);
  end

  parallel_sorter #(
    .data_width(data_width),
    .num_elem  (num_elem)
  ) u_sorter (
    .inps(r_count),
    .outp(w_sorted)
  );

  assign outp_inps = r_count;
  assign outp      = w_sorted;

endmodule

// File: tb/tb_parallel_sorter_selftest.sv
module tb_parallel_sorter_selftest;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;
  logic [5:0]  outp, outp_inps;
  logic [15:0] outp2, outp_inps2;

  int total = 0;
  int bad   = 0;
  int exp_cnt  = 0;
  int exp_cnt2 = 0;

  always #5 clk = ~clk;

  parallel_sorter_selftest #(.data_width(3), .num_elem(2)) dut (
    .clk(clk), .rst(rst), .outp(outp), .outp_inps(outp_inps)
  );

  parallel_sorter_selftest #(.data_width(4), .num_elem(4)) dut2 (
    .clk(clk), .rst(rst2), .outp(outp2), .outp_inps(outp_inps2)
  );

  // Reference: histogram of word values, then emit values in ascending order
  function automatic logic [15:0] ref_sort(input logic [15:0] v, input int dw, input int n);
    int hist[16];
    int slot;
    logic [15:0] r;
    for (int k = 0; k < 16; k++) hist[k] = 0;
    for (int i = 0; i < n; i++) hist[int'((v >> (i * dw)) & 16'((1 << dw) - 1))]++;
    r = '0;
    slot = 0;
    for (int val = 0; val < (1 << dw); val++)
      for (int c = 0; c < hist[val]; c++) begin
        r = r | (16'(val) << (slot * dw));
        slot++;
      end
    return r;
  endfunction

  // One clock for dut with given rst; model the counter
  task automatic step(input bit r);
    rst = r;
    @(posedge clk);
    #1;
    exp_cnt = r ? 0 : (exp_cnt + 1) % 64;
  endtask

  task automatic check_dut(input string name);
    logic [15:0] s;
    logic [5:0]  es;
    s  = ref_sort(16'(exp_cnt), 3, 2);
    es = s[5:0];
    total++;
    if (outp_inps !== 6'(exp_cnt)) begin
      bad++;
      $display("FAIL %s inps: got %0d want %0d", name, outp_inps, exp_cnt);
    end
    total++;
    if (outp !== es) begin
      bad++;
      $display("FAIL %s outp: got %0d want %0d (inps %0d)", name, outp, es, exp_cnt);
    end
  endtask

  task automatic test_reset();
    step(1); step(1);
    check_dut("reset");
    for (int k = 0; k < 4; k++) begin
      step(0);
      check_dut("count_after_reset");
    end
  endtask

  task automatic test_directed();
    int tgt[5]  = '{1, 8, 29, 45, 63};
    int want[5] = '{8, 8, 43, 45, 63};
    for (int t = 0; t < 5; t++) begin
      step(1);
      for (int c = 0; c < tgt[t]; c++) step(0);
      total++;
      if (outp_inps !== 6'(tgt[t]) || outp !== 6'(want[t])) begin
        bad++;
        $display("FAIL directed_%0d: inps %0d outp %0d want inps %0d outp %0d",
                 tgt[t], outp_inps, outp, tgt[t], want[t]);
      end
    end
    step(0);
    total++;
    if (outp_inps !== 6'd0 || outp !== 6'd0) begin
      bad++;
      $display("FAIL wrap: inps %0d outp %0d want 0 0", outp_inps, outp);
    end
    exp_cnt = 0;
  endtask

  task automatic test_mid_reset();
    step(1);
    for (int c = 0; c < 20; c++) step(0);
    check_dut("at_20");
    step(1);
    check_dut("mid_reset");
    step(0);
    check_dut("resume_1");
    step(0);
    check_dut("resume_2");
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 15) == 0);
      check_dut("random");
    end
  endtask

  // Full 16-bit sweep on the 4x4-bit instance: ascending + same multiset
  task automatic test_sweep();
    int hin[16], hout[16];
    logic [3:0] prev, cur;
    logic ok_order, ok_perm;
    logic [15:0] s;
    rst2 = 1'b1;
    @(posedge clk); #1;
    exp_cnt2 = 0;
    rst2 = 1'b0;
    for (int cyc = 0; cyc <= 65536; cyc++) begin
      for (int k = 0; k < 16; k++) begin hin[k] = 0; hout[k] = 0; end
      ok_order = 1'b1;
      prev = 4'd0;
      for (int i = 0; i < 4; i++) begin
        cur = outp2[i*4 +: 4];
        if (i > 0 && cur < prev) ok_order = 1'b0;
        prev = cur;
        hout[int'(cur)]++;
        hin[int'(outp_inps2[i*4 +: 4])]++;
      end
      ok_perm = 1'b1;
      for (int k = 0; k < 16; k++) if (hin[k] != hout[k]) ok_perm = 1'b0;
      total++;
      if (!ok_order || !ok_perm || $isunknown(outp2)) begin
        bad++;
        $display("FAIL sweep_prop: inps %h outp %h order %0b perm %0b",
                 outp_inps2, outp2, ok_order, ok_perm);
      end
      if (cyc % 97 == 0 || cyc >= 65534) begin
        s = ref_sort(16'(exp_cnt2), 4, 4);
        total++;
        if (outp_inps2 !== 16'(exp_cnt2) || outp2 !== s) begin
          bad++;
          $display("FAIL sweep_val: inps %h outp %h want inps %h outp %h",
                   outp_inps2, outp2, 16'(exp_cnt2), s);
        end
      end
      @(posedge clk); #1;
      exp_cnt2 = (exp_cnt2 + 1) % 65536;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mid_reset();
    test_random();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
